// File: rtl/crc_check_if.sv
// Byte-stream bus into the CRC checker: one byte per accepted clock, framed by sof/eof.
interface crc_check_if;
  logic [7:0] d;
  logic       d_valid;
  logic       sof;
  logic       eof;

  modport master (output d, d_valid, sof, eof);
  modport slave  (input  d, d_valid, sof, eof);
endinterface

// File: rtl/crc_check.sv
// CRC-16 (poly 0x1021, init 0) frame checker. The last two bytes of every frame
// are the trailer: ~bitrev(CRC[15:8]) then ~bitrev(CRC[7:0]). A two-byte delay
// line keeps trailer bytes out of the running CRC: a byte is folded in only when
// a newer byte pushes it out.
//
// state | meaning
// IDLE  | waiting for a sof byte; non-sof bytes are ignored
// RUN   | inside a frame, consuming payload/trailer bytes
module crc_check #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  crc_check_if.slave       bus,
  output logic [15:0]      crc_reg,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             len_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [15:0]      crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       dl0_q, dl0_d;   // most recent byte
  logic [7:0]       dl1_q, dl1_d;   // byte before that
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             len_q, len_d;

  logic [15:0]      crc_fin;
  logic [15:0]      exp_trl;

  // d[0] is first on the wire, so feeding bit 0 first equals bit-reverse then MSB-first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = {r[14:0], 1'b0} ^ (((b[i] ^ r[15]) == 1'b1) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

  // Next-state, delay-line shift, CRC update and trailer compare.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    dl0_d   = dl0_q;
    dl1_d   = dl1_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    err_d   = err_q;
    len_d   = len_q;

    // dl1 only holds a real byte once two bytes of the frame have been accepted.
    crc_fin = (cnt_q >= CNT_W'(2)) ? crc_step(crc_q, dl1_q) : crc_q;
    exp_trl = {~bitrev8(crc_fin[15:8]), ~bitrev8(crc_fin[7:0])};

    if (bus.d_valid) begin
      if (bus.sof) begin
        crc_d = 16'h0000;
        dl1_d = 8'h00;
        dl0_d = bus.d;
        cnt_d = CNT_W'(1);
        ok_d  = 1'b0;
        err_d = 1'b0;
        len_d = 1'b0;
        if (bus.eof) begin
          done_d  = 1'b1;
          len_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end else if (state_q == RUN) begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        crc_d = crc_fin;
        dl1_d = dl0_q;
        dl0_d = bus.d;
        if (bus.eof) begin
          done_d  = 1'b1;
          state_d = IDLE;
          if ({dl0_q, bus.d} == exp_trl) begin
            ok_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    end
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      crc_q   <= 16'h0000;
      cnt_q   <= '0;
      dl0_q   <= 8'h00;
      dl1_q   <= 8'h00;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      dl0_q   <= dl0_d;
      dl1_q   <= dl1_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      len_q   <= len_d;
    end
  end

  assign crc_reg  = crc_q;
  assign byte_cnt = cnt_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign crc_ok   = ok_q;
  assign crc_err  = err_q;
  assign len_err  = len_q;

endmodule

// File: tb/tb_crc_check.sv
module tb_crc_check;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] crc_reg;
  logic [15:0] byte_cnt;
  logic        busy, done, crc_ok, crc_err, len_err;

  crc_check_if bus ();

  crc_check #(.CNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .crc_reg  (crc_reg),
    .byte_cnt (byte_cnt),
    .busy     (busy),
    .done     (done),
    .crc_ok   (crc_ok),
    .crc_err  (crc_err),
    .len_err  (len_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  // Counts every cycle done is high; a stuck done shows up as extra counts.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    string          nm;
    logic [3:0][7:0] b;
    int             len;
    logic           ok, err, le;
    logic [15:0]    cnt;
    logic [15:0]    crc;
  } vec_t;

  function automatic vec_t mk(input string nm, input int len,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic ok, input logic err, input logic le,
                              input logic [15:0] cnt, input logic [15:0] crc);
    vec_t v;
    v.nm = nm; v.len = len;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.ok = ok; v.err = err; v.le = le; v.cnt = cnt; v.crc = crc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called just after a negedge; drives one accepted byte and returns at the next negedge.
  task automatic push(input logic [7:0] b, input logic s, input logic e);
    bus.d       = b;
    bus.d_valid = 1'b1;
    bus.sof     = s;
    bus.eof     = e;
    @(negedge clk);
    bus.d_valid = 1'b0;
    bus.sof     = 1'b0;
    bus.eof     = 1'b0;
  endtask

  // Sends a whole frame with gap idle cycles between bytes, then lets done fall.
  task automatic send_frame(input string nm, input logic [3:0][7:0] b, input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      push(b[i], i == 0, i == len - 1);
      if (i == len - 1) begin
        chk({nm, " done latency"}, {31'd0, done}, 32'd1);
      end else begin
        repeat (gap) @(negedge clk);
        if (gap > 0) chk({nm, " busy in gap"}, {31'd0, busy}, 32'd1);
      end
    end
    @(negedge clk);
    #1;
  endtask

  vec_t vecs[8];
  int   d0;

  initial begin
    vecs[0] = mk("zero_payload_byte", 3, 8'h00, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 16'd3, 16'h0000);
    vecs[1] = mk("p80_ok",            3, 8'h80, 8'hF7, 8'h7B, 8'h00, 1, 0, 0, 16'd3, 16'h1021);
    vecs[2] = mk("p80_bad_last",      3, 8'h80, 8'hF7, 8'h7A, 8'h00, 0, 1, 0, 16'd3, 16'h1021);
    vecs[3] = mk("two_byte_ok",       2, 8'hFF, 8'hFF, 8'h00, 8'h00, 1, 0, 0, 16'd2, 16'h0000);
    vecs[4] = mk("one_byte",          1, 8'h5A, 8'h00, 8'h00, 8'h00, 0, 0, 1, 16'd1, 16'h0000);
    vecs[5] = mk("two_byte_bad",      2, 8'hFE, 8'hFE, 8'h00, 8'h00, 0, 1, 0, 16'd2, 16'h0000);
    vecs[6] = mk("p80_00_ok",         4, 8'h80, 8'h00, 8'h33, 8'h73, 1, 0, 0, 16'd4, 16'h3331);
    vecs[7] = mk("p80_00_bad_first",  4, 8'h80, 8'h00, 8'h32, 8'h73, 0, 1, 0, 16'd4, 16'h3331);

    reset = 1'b1;
    bus.d = 8'h00; bus.d_valid = 1'b0; bus.sof = 1'b0; bus.eof = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst crc_reg",  {16'd0, crc_reg}, 32'h0);
    chk("rst byte_cnt", {16'd0, byte_cnt}, 32'h0);
    chk("rst busy",     {31'd0, busy}, 32'h0);
    chk("rst done",     {31'd0, done}, 32'h0);
    chk("rst flags",    {29'd0, crc_ok, crc_err, len_err}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    #1;

    // Table-driven frames
    for (int k = 0; k < 8; k++) begin
      d0 = done_cnt;
      send_frame(vecs[k].nm, vecs[k].b, vecs[k].len, 0);
      chk({vecs[k].nm, " done pulses"}, done_cnt - d0, 32'd1);
      chk({vecs[k].nm, " crc_ok"},   {31'd0, crc_ok},  {31'd0, vecs[k].ok});
      chk({vecs[k].nm, " crc_err"},  {31'd0, crc_err}, {31'd0, vecs[k].err});
      chk({vecs[k].nm, " len_err"},  {31'd0, len_err}, {31'd0, vecs[k].le});
      chk({vecs[k].nm, " byte_cnt"}, {16'd0, byte_cnt}, {16'd0, vecs[k].cnt});
      chk({vecs[k].nm, " crc_reg"},  {16'd0, crc_reg},  {16'd0, vecs[k].crc});
      chk({vecs[k].nm, " busy"},     {31'd0, busy}, 32'd0);
    end

    // sof mid-frame aborts the first frame silently
    d0 = done_cnt;
    push(8'h11, 1, 0);
    push(8'h22, 0, 0);
    push(8'h33, 0, 0);
    push(8'h44, 0, 0);
    push(8'h55, 0, 0);
    #1;
    chk("abort busy", {31'd0, busy}, 32'd1);
    chk("abort cnt5", {16'd0, byte_cnt}, 32'd5);
    send_frame("abort_new", vecs[0].b, 3, 0);
    chk("abort done pulses", done_cnt - d0, 32'd1);
    chk("abort crc_ok",      {31'd0, crc_ok}, 32'd1);
    chk("abort byte_cnt",    {16'd0, byte_cnt}, 32'd3);

    // d_valid gaps of 0..3 cycles give the same result
    for (int g = 0; g < 4; g++) begin
      d0 = done_cnt;
      send_frame("gap", vecs[1].b, 3, g);
      chk("gap done pulses", done_cnt - d0, 32'd1);
      chk("gap crc_ok",   {30'd0, crc_ok, crc_err}, 32'd2);
      chk("gap crc_reg",  {16'd0, crc_reg}, 32'h1021);
      chk("gap byte_cnt", {16'd0, byte_cnt}, 32'd3);
    end

    // Stray bytes in IDLE (including a lone eof) change nothing
    d0 = done_cnt;
    push(8'hAA, 0, 0);
    push(8'hFF, 0, 1);
    push(8'h12, 0, 0);
    @(negedge clk);
    #1;
    chk("stray busy",     {31'd0, busy}, 32'd0);
    chk("stray byte_cnt", {16'd0, byte_cnt}, 32'd3);
    chk("stray crc_reg",  {16'd0, crc_reg}, 32'h1021);
    chk("stray flags",    {29'd0, crc_ok, crc_err, len_err}, 32'b100);
    chk("stray done",     done_cnt - d0, 32'd0);

    // Reset mid-frame: asynchronous clear, no done, next frame clean
    d0 = done_cnt;
    push(8'h80, 1, 0);
    push(8'h00, 0, 0);
    push(8'h33, 0, 0);
    #1;
    chk("pre-rst crc_reg",  {16'd0, crc_reg}, 32'h1021);
    chk("pre-rst byte_cnt", {16'd0, byte_cnt}, 32'd3);
    #1;
    reset = 1'b1;
    #1;
    chk("async rst crc_reg",  {16'd0, crc_reg}, 32'h0);
    chk("async rst byte_cnt", {16'd0, byte_cnt}, 32'h0);
    chk("async rst busy",     {31'd0, busy}, 32'h0);
    chk("async rst flags",    {28'd0, done, crc_ok, crc_err, len_err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst no done", done_cnt - d0, 32'd0);
    d0 = done_cnt;
    send_frame("post_rst", vecs[1].b, 3, 0);
    chk("post_rst done pulses", done_cnt - d0, 32'd1);
    chk("post_rst crc_ok",  {30'd0, crc_ok, crc_err}, 32'd2);
    chk("post_rst crc_reg", {16'd0, crc_reg}, 32'h1021);

    // Bit-order check: payload 0x01 is 0x80 after reversal
    d0 = done_cnt;
    send_frame("p01_ok", {8'h00, 8'hEE, 8'h76, 8'h01}, 3, 1);
    chk("p01 done pulses", done_cnt - d0, 32'd1);
    chk("p01 crc_ok",  {30'd0, crc_ok, crc_err}, 32'd2);
    chk("p01 crc_reg", {16'd0, crc_reg}, 32'h9188);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
